// File: rtl/tag_stream_pkg.sv
// Shared definitions for the synthetic time-tag stream.
// Used by the generator and by the measurement-side receiver.
//   TAGTIME_W   - tagtime width (1/3 ps units)
//   CHANNEL_W   - signed channel number width
//   MAX_CHANNEL - highest rising-edge channel number
package tag_stream_pkg;

  localparam int unsigned TAGTIME_W   = 64;
  localparam int unsigned CHANNEL_W   = 6;
  localparam int unsigned MAX_CHANNEL = 18;
  // Width of the channel-count configuration field.
  localparam int unsigned NUM_CH_W    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StGap
  } state_e;

  typedef struct packed {
    logic [TAGTIME_W-1:0]        tagtime;
    logic signed [CHANNEL_W-1:0] channel;
  } tag_event_t;

  // Channel count 0 behaves as 1; anything beyond the last channel saturates.
  function automatic logic [NUM_CH_W-1:0] clamp_channels(input logic [NUM_CH_W-1:0] n);
    logic [NUM_CH_W-1:0] max_n;
    max_n = NUM_CH_W'(MAX_CHANNEL);
    if (n == '0) begin
      return NUM_CH_W'(1);
    end
    if (n > max_n) begin
      return max_n;
    end
    return n;
  endfunction

endpackage

// File: rtl/tag_lane_calc.sv
// Per-lane event calculator (purely combinational).
// Ports:
//   base      - tagtime of lane 0 for the current word
//   off       - this lane's tagtime offset (Lane * period)
//   ch0       - zero-based channel index of lane 0, always < num_ch
//   num_ch    - clamped channel count, 1..MAX_CHANNEL
//   remaining - events still to emit, including this word
//   falling   - negate channel numbers
//   ev        - lane tagtime and channel
//   keep      - lane carries a real event
module tag_lane_calc
  import tag_stream_pkg::*;
#(
  parameter int unsigned Lane = 0
) (
  input  logic [TAGTIME_W-1:0] base,
  input  logic [TAGTIME_W-1:0] off,
  input  logic [NUM_CH_W-1:0]  ch0,
  input  logic [NUM_CH_W-1:0]  num_ch,
  input  logic [31:0]          remaining,
  input  logic                 falling,
  output tag_event_t           ev,
  output logic                 keep
);

  logic [7:0]           lane_mod;
  logic [7:0]           idx;
  logic [CHANNEL_W-1:0] mag;

  always_comb begin
    // Lane may exceed num_ch, so reduce it first; ch0 < num_ch keeps the
    // sum below 2*num_ch and a single conditional subtract finishes the wrap.
    lane_mod = 8'(32'(Lane) % 32'(num_ch));
    idx      = {3'd0, ch0} + lane_mod;
    if (idx >= {3'd0, num_ch}) begin
      idx = idx - {3'd0, num_ch};
    end
    mag        = CHANNEL_W'(idx + 8'd1);
    ev.tagtime = base + off;
    ev.channel = falling ? -mag : mag;
    keep       = (32'(Lane) < remaining);
  end

endmodule

// File: rtl/tag_stream_generator.sv
// Synthetic time-tag stream source: emits words of WORD_WIDTH evenly spaced
// events with rotating channel numbers on an AXI-Stream style interface.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   cfg_start           - start pulse, honoured only when idle
//   cfg_abort           - stop request, honoured at the next word boundary
//   cfg_first_time      - tagtime of event 0
//   cfg_period          - tagtime increment between events
//   cfg_num_events      - total events to emit
//   cfg_num_channels    - channels to rotate through (clamped to 1..18)
//   cfg_falling         - emit negative channel numbers
//   cfg_gap             - idle cycles after each accepted word
//   busy                - run in progress
//   done                - one-cycle pulse on normal completion
//   m_axis_tvalid/ready - stream handshake
//   m_axis_tagtime      - per-lane tagtime, lane i at [i*64 +: 64]
//   m_axis_channel      - per-lane channel, lane i at [i*6 +: 6]
//   m_axis_tkeep        - per-lane event valid
module tag_stream_generator
  import tag_stream_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic                                cfg_abort,
  input  logic [TAGTIME_W-1:0]                cfg_first_time,
  input  logic [31:0]                         cfg_period,
  input  logic [31:0]                         cfg_num_events,
  input  logic [NUM_CH_W-1:0]                 cfg_num_channels,
  input  logic                                cfg_falling,
  input  logic [7:0]                          cfg_gap,
  output logic                                busy,
  output logic                                done,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [TAGTIME_W*WORD_WIDTH-1:0]     m_axis_tagtime,
  output logic signed [CHANNEL_W*WORD_WIDTH-1:0] m_axis_channel,
  output logic [WORD_WIDTH-1:0]               m_axis_tkeep
);

  state_e state_q;

  // Configuration captured at start.
  logic [TAGTIME_W-1:0] first_q;
  logic [31:0]          period_q;
  logic [31:0]          num_events_q;
  logic [NUM_CH_W-1:0]  num_ch_q;
  logic                 falling_q;
  logic [7:0]           gap_q;

  // Run state.
  logic [TAGTIME_W-1:0] off_q [WORD_WIDTH];
  logic [TAGTIME_W-1:0] step_q;
  logic [TAGTIME_W-1:0] base_q;
  logic [31:0]          rem_q;
  logic [NUM_CH_W-1:0]  ch0_q;
  logic [NUM_CH_W-1:0]  n_q;
  logic [NUM_CH_W-1:0]  ww_mod_q;
  logic [7:0]           gap_cnt_q;
  logic                 abort_pend_q;

  // Registered outputs.
  logic                              tvalid_q;
  logic                              busy_q;
  logic                              done_q;
  logic [TAGTIME_W*WORD_WIDTH-1:0]   tagtime_q;
  logic [CHANNEL_W*WORD_WIDTH-1:0]   channel_q;
  logic [WORD_WIDTH-1:0]             tkeep_q;

  // Next-word datapath.
  logic                            hs;
  logic                            abort_now;
  logic [NUM_CH_W-1:0]             n_clamp;
  logic [NUM_CH_W-1:0]             ww_mod_load;
  logic [TAGTIME_W-1:0]            base_nxt;
  logic [NUM_CH_W:0]               ch0_sum;
  logic [NUM_CH_W-1:0]             ch0_nxt;
  logic [31:0]                     rem_take;
  logic [31:0]                     rem_nxt;
  logic [TAGTIME_W-1:0]            word_base;
  logic [NUM_CH_W-1:0]             word_ch0;
  logic [31:0]                     word_rem;
  logic [TAGTIME_W*WORD_WIDTH-1:0] word_tagtime;
  logic [CHANNEL_W*WORD_WIDTH-1:0] word_channel;
  logic [WORD_WIDTH-1:0]           word_keep;
  tag_event_t                      lane_ev [WORD_WIDTH];

  always_comb begin
    hs          = tvalid_q & m_axis_tready;
    abort_now   = cfg_abort | abort_pend_q;
    n_clamp     = clamp_channels(num_ch_q);
    ww_mod_load = NUM_CH_W'(32'(WORD_WIDTH) % 32'(n_clamp));
    base_nxt    = base_q + step_q;
    ch0_sum     = {1'b0, ch0_q} + {1'b0, ww_mod_q};
    ch0_nxt     = (ch0_sum >= {1'b0, n_q}) ? NUM_CH_W'(ch0_sum - {1'b0, n_q})
                                           : ch0_sum[NUM_CH_W-1:0];
    rem_take    = (rem_q < 32'(WORD_WIDTH)) ? rem_q : 32'(WORD_WIDTH);
    rem_nxt     = rem_q - rem_take;
    // The lanes always see the word that will be on the bus next cycle:
    // the advanced counters after a handshake, the current ones otherwise.
    word_base   = hs ? base_nxt : base_q;
    word_ch0    = hs ? ch0_nxt : ch0_q;
    word_rem    = hs ? rem_nxt : rem_q;
  end

  for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_lane
    tag_lane_calc #(
      .Lane(i)
    ) u_lane (
      .base     (word_base),
      .off      (off_q[i]),
      .ch0      (word_ch0),
      .num_ch   (n_q),
      .remaining(word_rem),
      .falling  (falling_q),
      .ev       (lane_ev[i]),
      .keep     (word_keep[i])
    );
    assign word_tagtime[i*TAGTIME_W +: TAGTIME_W] = lane_ev[i].tagtime;
    assign word_channel[i*CHANNEL_W +: CHANNEL_W] = lane_ev[i].channel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      first_q      <= '0;
      period_q     <= '0;
      num_events_q <= '0;
      num_ch_q     <= '0;
      falling_q    <= 1'b0;
      gap_q        <= '0;
      for (int i = 0; i < WORD_WIDTH; i++) begin
        off_q[i] <= '0;
      end
      step_q       <= '0;
      base_q       <= '0;
      rem_q        <= '0;
      ch0_q        <= '0;
      n_q          <= NUM_CH_W'(1);
      ww_mod_q     <= '0;
      gap_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      tvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tagtime_q    <= '0;
      channel_q    <= '0;
      tkeep_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          abort_pend_q <= 1'b0;
          if (cfg_start) begin
            first_q      <= cfg_first_time;
            period_q     <= cfg_period;
            num_events_q <= cfg_num_events;
            num_ch_q     <= cfg_num_channels;
            falling_q    <= cfg_falling;
            gap_q        <= cfg_gap;
            busy_q       <= 1'b1;
            state_q      <= StLoad;
          end
        end

        StLoad: begin
          for (int i = 0; i < WORD_WIDTH; i++) begin
            off_q[i] <= 64'(i) * {32'd0, period_q};
          end
          step_q   <= 64'(WORD_WIDTH) * {32'd0, period_q};
          base_q   <= first_q;
          rem_q    <= num_events_q;
          ch0_q    <= '0;
          n_q      <= n_clamp;
          ww_mod_q <= ww_mod_load;
          if (num_events_q == '0) begin
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= StIdle;
          end else begin
            abort_pend_q <= abort_pend_q | cfg_abort;
            state_q      <= StSend;
          end
        end

        StSend: begin
          if (!tvalid_q) begin
            // First presentation after LOAD.
            abort_pend_q <= abort_pend_q | cfg_abort;
            tvalid_q     <= 1'b1;
            tagtime_q    <= word_tagtime;
            channel_q    <= word_channel;
            tkeep_q      <= word_keep;
          end else if (m_axis_tready) begin
            base_q <= base_nxt;
            ch0_q  <= ch0_nxt;
            rem_q  <= rem_nxt;
            if (abort_now || rem_nxt == '0 || gap_q != '0) begin
              tvalid_q  <= 1'b0;
              tagtime_q <= '0;
              channel_q <= '0;
              tkeep_q   <= '0;
            end else begin
              tagtime_q <= word_tagtime;
              channel_q <= word_channel;
              tkeep_q   <= word_keep;
            end
            if (abort_now) begin
              abort_pend_q <= 1'b0;
              busy_q       <= 1'b0;
              state_q      <= StIdle;
            end else if (rem_nxt == '0) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else if (gap_q != '0) begin
              gap_cnt_q <= gap_q;
              state_q   <= StGap;
            end
          end else begin
            // Stalled: word held, abort remembered for the handshake.
            abort_pend_q <= abort_pend_q | cfg_abort;
          end
        end

        StGap: begin
          if (abort_now) begin
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end else if (gap_cnt_q == 8'd1) begin
            // Present on the edge ending the last gap cycle so the bus is
            // idle for exactly cfg_gap cycles.
            tvalid_q  <= 1'b1;
            tagtime_q <= word_tagtime;
            channel_q <= word_channel;
            tkeep_q   <= word_keep;
            state_q   <= StSend;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tagtime = tagtime_q;
  assign m_axis_channel = channel_q;
  assign m_axis_tkeep   = tkeep_q;

endmodule

// File: tb/tb_tag_stream_generator.sv
// Directed bench for tag_stream_generator (WORD_WIDTH = 4).
module tb_tag_stream_generator;

  localparam int WW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic              cfg_abort;
  logic [63:0]       cfg_first_time;
  logic [31:0]       cfg_period;
  logic [31:0]       cfg_num_events;
  logic [4:0]        cfg_num_channels;
  logic              cfg_falling;
  logic [7:0]        cfg_gap;
  logic              busy;
  logic              done;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [64*WW-1:0]  m_axis_tagtime;
  logic signed [6*WW-1:0] m_axis_channel;
  logic [WW-1:0]     m_axis_tkeep;

  tag_stream_generator #(
    .WORD_WIDTH(WW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_first_time  (cfg_first_time),
    .cfg_period      (cfg_period),
    .cfg_num_events  (cfg_num_events),
    .cfg_num_channels(cfg_num_channels),
    .cfg_falling     (cfg_falling),
    .cfg_gap         (cfg_gap),
    .busy            (busy),
    .done            (done),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .m_axis_tagtime  (m_axis_tagtime),
    .m_axis_channel  (m_axis_channel),
    .m_axis_tkeep    (m_axis_tkeep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Capture storage filled by run_capture.
  logic [63:0]       cap_tag [16][WW];
  logic signed [5:0] cap_ch  [16][WW];
  logic [WW-1:0]     cap_keep[16];
  int                n_words;
  int                done_cnt;
  int                done_cyc;
  int                last_hs;
  logic              vld_hist [64];
  logic              busy_hist[64];
  logic              done_hist[64];
  logic [63:0]       tag0_hist[64];
  logic [5:0]        ch0_hist [64];
  logic [WW-1:0]     keep_hist[64];

  task automatic start_run(input logic [63:0] first, input logic [31:0] period,
                           input logic [31:0] events, input logic [4:0] nch,
                           input logic falling, input logic [7:0] gap);
    cfg_first_time   = first;
    cfg_period       = period;
    cfg_num_events   = events;
    cfg_num_channels = nch;
    cfg_falling      = falling;
    cfg_gap          = gap;
    cfg_start        = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  // Cycle 0 is the cycle right after the start pulse was sampled.
  task automatic run_capture(input int ncyc, input logic [63:0] stall, input int abort_c,
                             input int restart_c, input int rst_c);
    n_words  = 0;
    done_cnt = 0;
    done_cyc = -1;
    last_hs  = -1;
    for (int c = 0; c < ncyc; c++) begin
      m_axis_tready = ~stall[c];
      cfg_abort     = (c == abort_c);
      rst           = (c == rst_c);
      cfg_start     = (c == restart_c);
      if (c == restart_c) begin
        cfg_first_time = 64'h1234_0000;
        cfg_num_events = 32'd3;
      end
      @(negedge clk);
      vld_hist[c]  = m_axis_tvalid;
      busy_hist[c] = busy;
      done_hist[c] = done;
      tag0_hist[c] = m_axis_tagtime[63:0];
      ch0_hist[c]  = m_axis_channel[5:0];
      keep_hist[c] = m_axis_tkeep;
      if (m_axis_tvalid && m_axis_tready) begin
        if (n_words < 16) begin
          for (int l = 0; l < WW; l++) begin
            cap_tag[n_words][l] = m_axis_tagtime[l*64 +: 64];
            cap_ch[n_words][l]  = m_axis_channel[l*6 +: 6];
          end
          cap_keep[n_words] = m_axis_tkeep;
        end
        n_words++;
        last_hs = c;
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      @(posedge clk);
      #1;
    end
    m_axis_tready = 1'b1;
    cfg_abort     = 1'b0;
    cfg_start     = 1'b0;
    rst           = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; m_axis_tready = 1'b1;
    cfg_first_time = '0; cfg_period = '0; cfg_num_events = '0;
    cfg_num_channels = '0; cfg_falling = 1'b0; cfg_gap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tkeep !== '0) begin errors++; $display("FAIL reset_tkeep: got %h expected 0", m_axis_tkeep); end
    checks++; if (m_axis_tagtime !== '0) begin errors++; $display("FAIL reset_tagtime: got %h expected 0", m_axis_tagtime); end
    checks++; if (m_axis_channel !== '0) begin errors++; $display("FAIL reset_channel: got %h expected 0", m_axis_channel); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic [63:0] et [3][WW] = '{'{64'd1000, 64'd4000, 64'd7000, 64'd10000},
                                '{64'd13000, 64'd16000, 64'd19000, 64'd22000},
                                '{64'd25000, 64'd28000, 64'd31000, 64'd34000}};
    int          ec [3][WW] = '{'{1, 2, 3, 1}, '{2, 3, 1, 2}, '{3, 1, 2, 3}};
    logic [WW-1:0] ek [3]   = '{4'b1111, 4'b1111, 4'b0011};
    start_run(64'd1000, 32'd3000, 32'd10, 5'd3, 1'b0, 8'd0);
    run_capture(10, 64'd0, -1, -1, -1);
    checks++; if (busy_hist[0] !== 1'b1) begin errors++; $display("FAIL basic_busy_load: got %b expected 1", busy_hist[0]); end
    checks++; if (vld_hist[1] !== 1'b0) begin errors++; $display("FAIL basic_tvalid_early: got %b expected 0", vld_hist[1]); end
    checks++; if (vld_hist[2] !== 1'b1) begin errors++; $display("FAIL basic_tvalid_latency: got %b expected 1", vld_hist[2]); end
    checks++; if (n_words !== 3) begin errors++; $display("FAIL basic_words: got %0d expected 3", n_words); end
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (cap_keep[w] !== ek[w]) begin
        errors++; $display("FAIL basic_keep_w%0d: got %b expected %b", w, cap_keep[w], ek[w]);
      end
      for (int l = 0; l < WW; l++) begin
        if (ek[w][l]) begin
          checks++;
          if (cap_tag[w][l] !== et[w][l]) begin
            errors++; $display("FAIL basic_tag_w%0d_l%0d: got %0d expected %0d", w, l, cap_tag[w][l], et[w][l]);
          end
          checks++;
          if (int'(cap_ch[w][l]) !== ec[w][l]) begin
            errors++; $display("FAIL basic_ch_w%0d_l%0d: got %0d expected %0d", w, l, cap_ch[w][l], ec[w][l]);
          end
        end
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 5", done_cyc); end
    checks++; if (busy_hist[5] !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_hist[5]); end
  endtask

  task automatic test_backpressure;
    logic [63:0] et1 [WW] = '{64'd13000, 64'd16000, 64'd19000, 64'd22000};
    int          ec1 [WW] = '{2, 3, 1, 2};
    start_run(64'd1000, 32'd3000, 32'd10, 5'd3, 1'b0, 8'd0);
    run_capture(12, 64'h38, -1, -1, -1);
    // Word 1 is presented at cycle 3 and stalled through cycle 5.
    for (int c = 3; c <= 6; c++) begin
      checks++;
      if (vld_hist[c] !== 1'b1 || tag0_hist[c] !== 64'd13000 || ch0_hist[c] !== 6'd2 ||
          keep_hist[c] !== 4'b1111) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got vld=%b tag=%0d ch=%0d keep=%b expected 1/13000/2/1111",
                 c, vld_hist[c], tag0_hist[c], ch0_hist[c], keep_hist[c]);
      end
    end
    checks++; if (n_words !== 3) begin errors++; $display("FAIL bp_words: got %0d expected 3", n_words); end
    for (int l = 0; l < WW; l++) begin
      checks++;
      if (cap_tag[1][l] !== et1[l] || int'(cap_ch[1][l]) !== ec1[l]) begin
        errors++; $display("FAIL bp_w1_l%0d: got %0d/%0d expected %0d/%0d", l, cap_tag[1][l], cap_ch[1][l], et1[l], ec1[l]);
      end
    end
    checks++; if (cap_tag[2][0] !== 64'd25000) begin errors++; $display("FAIL bp_w2_tag: got %0d expected 25000", cap_tag[2][0]); end
    checks++; if (done_cyc !== 8 || done_cnt !== 1) begin errors++; $display("FAIL bp_done: got cycle %0d count %0d expected 8/1", done_cyc, done_cnt); end
  endtask

  task automatic test_gap;
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    start_run(64'd1000, 32'd3000, 32'd12, 5'd3, 1'b0, 8'd2);
    run_capture(14, 64'd0, -1, -1, -1);
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (vld_hist[c+2] !== pat[c]) begin
        errors++; $display("FAIL gap_tvalid_c%0d: got %b expected %b", c + 2, vld_hist[c+2], pat[c]);
      end
    end
    checks++; if (keep_hist[3] !== 4'b0000) begin errors++; $display("FAIL gap_idle_keep: got %b expected 0000", keep_hist[3]); end
    checks++; if (n_words !== 3) begin errors++; $display("FAIL gap_words: got %0d expected 3", n_words); end
    checks++; if (cap_tag[2][3] !== 64'd34000 || int'(cap_ch[2][3]) !== 3) begin errors++; $display("FAIL gap_w2_l3: got %0d/%0d expected 34000/3", cap_tag[2][3], cap_ch[2][3]); end
    checks++; if (cap_keep[2] !== 4'b1111) begin errors++; $display("FAIL gap_w2_keep: got %b expected 1111", cap_keep[2]); end
    checks++; if (done_cyc !== 9 || done_cnt !== 1) begin errors++; $display("FAIL gap_done: got cycle %0d count %0d expected 9/1", done_cyc, done_cnt); end
  endtask

  task automatic test_zero;
    int vld_seen = 0;
    start_run(64'd500, 32'd7, 32'd0, 5'd3, 1'b0, 8'd0);
    run_capture(8, 64'd0, -1, -1, -1);
    for (int c = 0; c < 8; c++) if (vld_hist[c]) vld_seen++;
    checks++; if (vld_seen !== 0) begin errors++; $display("FAIL zero_tvalid: got %0d valid cycles expected 0", vld_seen); end
    checks++; if (done_cnt !== 1 || done_cyc !== 1) begin errors++; $display("FAIL zero_done: got cycle %0d count %0d expected 1/1", done_cyc, done_cnt); end
    checks++; if (busy_hist[0] !== 1'b1 || busy_hist[1] !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b%b expected 10", busy_hist[0], busy_hist[1]); end
  endtask

  task automatic test_clamp_restart;
    int late_busy = 0;
    start_run(64'd0, 32'd1, 32'd20, 5'd25, 1'b0, 8'd0);
    run_capture(24, 64'd0, -1, 4, -1);
    checks++; if (n_words !== 5) begin errors++; $display("FAIL clamp_words: got %0d expected 5", n_words); end
    for (int w = 0; w < 5; w++) begin
      for (int l = 0; l < WW; l++) begin
        if (4 * w + l < 20) begin
          checks++;
          if (cap_tag[w][l] !== 64'(4 * w + l) || int'(cap_ch[w][l]) !== ((4 * w + l) % 18) + 1) begin
            errors++;
            $display("FAIL clamp_w%0d_l%0d: got %0d/%0d expected %0d/%0d", w, l, cap_tag[w][l],
                     cap_ch[w][l], 4 * w + l, ((4 * w + l) % 18) + 1);
          end
        end
      end
    end
    checks++; if (cap_keep[4] !== 4'b1111) begin errors++; $display("FAIL clamp_w4_keep: got %b expected 1111", cap_keep[4]); end
    for (int c = 8; c < 24; c++) if (busy_hist[c]) late_busy++;
    checks++; if (late_busy !== 0 || done_cnt !== 1) begin errors++; $display("FAIL restart_ignored: got %0d busy cycles, %0d done expected 0/1", late_busy, done_cnt); end
  endtask

  task automatic test_wrap_falling;
    logic [63:0] et [WW] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
    int          ec [WW] = '{-1, -2, -1, -2};
    start_run(64'hFFFF_FFFF_FFFF_FFFE, 32'd1, 32'd4, 5'd2, 1'b1, 8'd0);
    run_capture(6, 64'd0, -1, -1, -1);
    checks++; if (n_words !== 1 || cap_keep[0] !== 4'b1111) begin errors++; $display("FAIL wrap_words: got %0d keep %b expected 1/1111", n_words, cap_keep[0]); end
    for (int l = 0; l < WW; l++) begin
      checks++;
      if (cap_tag[0][l] !== et[l] || int'(cap_ch[0][l]) !== ec[l]) begin
        errors++; $display("FAIL wrap_l%0d: got %h/%0d expected %h/%0d", l, cap_tag[0][l], cap_ch[0][l], et[l], ec[l]);
      end
    end
    checks++; if (done_cyc !== 3) begin errors++; $display("FAIL wrap_done: got %0d expected 3", done_cyc); end
  endtask

  task automatic test_abort;
    int late_vld = 0;
    start_run(64'd1000, 32'd3000, 32'd10, 5'd3, 1'b0, 8'd0);
    run_capture(14, 64'h38, 3, -1, -1);
    checks++;
    if (vld_hist[5] !== 1'b1 || tag0_hist[5] !== 64'd13000) begin
      errors++; $display("FAIL abort_hold: got vld=%b tag=%0d expected 1/13000", vld_hist[5], tag0_hist[5]);
    end
    checks++; if (n_words !== 2 || last_hs !== 6) begin errors++; $display("FAIL abort_words: got %0d (last %0d) expected 2 (6)", n_words, last_hs); end
    checks++; if (cap_tag[1][0] !== 64'd13000) begin errors++; $display("FAIL abort_w1_tag: got %0d expected 13000", cap_tag[1][0]); end
    for (int c = 7; c < 14; c++) if (vld_hist[c] || busy_hist[c]) late_vld++;
    checks++; if (late_vld !== 0) begin errors++; $display("FAIL abort_idle: got %0d active cycles expected 0", late_vld); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_reset_mid_gap;
    int late_vld = 0;
    start_run(64'd1000, 32'd3000, 32'd12, 5'd3, 1'b0, 8'd5);
    run_capture(16, 64'd0, -1, -1, 4);
    checks++; if (busy_hist[4] !== 1'b1) begin errors++; $display("FAIL rstgap_busy_before: got %b expected 1", busy_hist[4]); end
    checks++;
    if (busy_hist[5] !== 1'b0 || vld_hist[5] !== 1'b0 || keep_hist[5] !== '0 ||
        tag0_hist[5] !== '0 || ch0_hist[5] !== '0 || done_hist[5] !== 1'b0) begin
      errors++;
      $display("FAIL rstgap_outputs: got busy=%b vld=%b keep=%b tag=%0d ch=%0d done=%b expected all 0",
               busy_hist[5], vld_hist[5], keep_hist[5], tag0_hist[5], ch0_hist[5], done_hist[5]);
    end
    for (int c = 5; c < 16; c++) if (vld_hist[c] || busy_hist[c]) late_vld++;
    checks++; if (late_vld !== 0 || n_words !== 1) begin errors++; $display("FAIL rstgap_discard: got %0d active cycles, %0d words expected 0/1", late_vld, n_words); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_zero();
    test_clamp_restart();
    test_wrap_falling();
    test_abort();
    test_reset_mid_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
